riscv_dmem_arbiter: RTL and testbench

//  Shares one single-port data memory between the CPU load/store path and a DMA/debug requester.

---
 rtl/riscv_dmem_arbiter_pkg.sv | 31 +++
 rtl/riscv_dmem_arbiter_pick.sv | 24 ++
 rtl/riscv_dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_riscv_dmem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter.
//   XLEN      : data/address width
//   BSEL_W    : byte-enable width (XLEN/8)
//   LAT_W     : latency counter width (MEM_LAT up to 7)
//   STARVE_W  : starvation counter width (STARVE_LIMIT up to 15)
//   arb_state_e, req_id_e, mem_req_t : FSM states, requester ids, access payload
package riscv_dmem_arbiter_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned BSEL_W   = XLEN / 8;
   localparam int unsigned LAT_W    = 3;
   localparam int unsigned STARVE_W = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DMA = 1'b1
   } req_id_e;

   typedef struct packed {
      logic              wen;
      logic [XLEN-1:0]   addr;
      logic [XLEN-1:0]   wr_data;
      logic [BSEL_W-1:0] byte_sel;
   } mem_req_t;

endpackage

// File: rtl/riscv_dmem_arbiter_pick.sv
// Combinational winner select between the CPU and DMA requesters.
//   cpu_req, dma_req : pending requests
//   prefer_dma       : DMA wins a tie (round-robin pointer or starvation flag)
//   any_req_c        : at least one request pending
//   winner_c         : selected requester (valid when any_req_c)
module riscv_dmem_arbiter_pick
   import riscv_dmem_arbiter_pkg::*;
(
   input  logic    cpu_req,
   input  logic    dma_req,
   input  logic    prefer_dma,
   output logic    any_req_c,
   output req_id_e winner_c
);

   always_comb begin
      any_req_c = cpu_req | dma_req;
      winner_c  = REQ_CPU;
      if (dma_req && (!cpu_req || prefer_dma)) begin
         winner_c = REQ_DMA;
      end
   end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Shares one single-port data memory between the CPU load/store path and a
// DMA/debug requester. One access in flight; fixed memory latency MEM_LAT.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_cpu_* / o_cpu_*       : CPU request fields, grant, completion, load data
//   i_dma_* / o_dma_*       : DMA request fields, grant, completion, load data
//   o_mem_*, i_mem_rd_data  : memory macro interface
// Config macro RISCV_DMEM_ARB_RR_EN: round-robin arbitration instead of
// CPU priority with starvation counter (STARVE_LIMIT then unused).
module riscv_dmem_arbiter
   import riscv_dmem_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LAT      = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cpu_req,
   input  logic              i_cpu_wen,
   input  logic [XLEN-1:0]   i_cpu_addr,
   input  logic [XLEN-1:0]   i_cpu_wr_data,
   input  logic [BSEL_W-1:0] i_cpu_byte_sel,
   output logic              o_cpu_gnt,
   output logic              o_cpu_rvalid,
   output logic [XLEN-1:0]   o_cpu_rd_data,
   input  logic              i_dma_req,
   input  logic              i_dma_wen,
   input  logic [XLEN-1:0]   i_dma_addr,
   input  logic [XLEN-1:0]   i_dma_wr_data,
   input  logic [BSEL_W-1:0] i_dma_byte_sel,
   output logic              o_dma_gnt,
   output logic              o_dma_rvalid,
   output logic [XLEN-1:0]   o_dma_rd_data,
   output logic              o_mem_en,
   output logic              o_mem_wen,
   output logic [XLEN-1:0]   o_mem_addr,
   output logic [XLEN-1:0]   o_mem_wr_data,
   output logic [BSEL_W-1:0] o_mem_byte_sel,
   input  logic [XLEN-1:0]   i_mem_rd_data
);

   arb_state_e       state;
   logic [LAT_W-1:0] lat_cnt;
   req_id_e          owner;
   logic             owner_wen;
   mem_req_t         sel_acc;
   logic             win_open;
   logic             grant;
   logic             cmpl;
   logic             any_req;
   logic             prefer_dma;
   req_id_e          winner;

`ifdef RISCV_DMEM_ARB_RR_EN
   req_id_e          rr_ptr;
   assign prefer_dma = (rr_ptr == REQ_DMA);
`else
   logic [STARVE_W-1:0] starve_cnt;
   assign prefer_dma = (starve_cnt == STARVE_W'(STARVE_LIMIT));
`endif

   riscv_dmem_arbiter_pick u_pick (
      .cpu_req    (i_cpu_req),
      .dma_req    (i_dma_req),
      .prefer_dma (prefer_dma),
      .any_req_c  (any_req),
      .winner_c   (winner)
   );

   // Grant window: idle, or the completion cycle of the outstanding access.
   always_comb begin
      win_open = (state == ARB_IDLE) || (lat_cnt == LAT_W'(1));
      cmpl     = !i_rst && (state == ARB_BUSY) && (lat_cnt == LAT_W'(1));
      grant    = !i_rst && win_open && any_req;
      sel_acc  = (winner == REQ_DMA) ?
                 '{wen: i_dma_wen, addr: i_dma_addr, wr_data: i_dma_wr_data, byte_sel: i_dma_byte_sel} :
                 '{wen: i_cpu_wen, addr: i_cpu_addr, wr_data: i_cpu_wr_data, byte_sel: i_cpu_byte_sel};
   end

   // Request mux toward memory; strobes are zero outside a grant.
   always_comb begin
      o_cpu_gnt      = grant && (winner == REQ_CPU);
      o_dma_gnt      = grant && (winner == REQ_DMA);
      o_mem_en       = grant;
      o_mem_wen      = grant && sel_acc.wen;
      o_mem_addr     = sel_acc.addr;
      o_mem_wr_data  = sel_acc.wr_data;
      o_mem_byte_sel = grant ? sel_acc.byte_sel : '0;
   end

   // Response demux: completion goes to the registered owner, not the new winner.
   always_comb begin
      o_cpu_rvalid  = cmpl && (owner == REQ_CPU);
      o_dma_rvalid  = cmpl && (owner == REQ_DMA);
      o_cpu_rd_data = (o_cpu_rvalid && !owner_wen) ? i_mem_rd_data : '0;
      o_dma_rd_data = (o_dma_rvalid && !owner_wen) ? i_mem_rd_data : '0;
   end

   // FSM, latency tracking, ownership and fairness state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= ARB_IDLE;
         lat_cnt   <= '0;
         owner     <= REQ_CPU;
         owner_wen <= 1'b0;
`ifdef RISCV_DMEM_ARB_RR_EN
         rr_ptr    <= REQ_CPU;
`else
         starve_cnt <= '0;
`endif
      end else begin
         if (grant) begin
            state     <= ARB_BUSY;
            lat_cnt   <= LAT_W'(MEM_LAT);
            owner     <= winner;
            owner_wen <= sel_acc.wen;
         end else if (cmpl) begin
            state   <= ARB_IDLE;
            lat_cnt <= '0;
         end else if (state == ARB_BUSY) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
         end
`ifdef RISCV_DMEM_ARB_RR_EN
         if (grant) begin
            rr_ptr <= (winner == REQ_CPU) ? REQ_DMA : REQ_CPU;
         end
`else
         // Count CPU wins only while DMA is actually waiting.
         if (!i_dma_req || (grant && (winner == REQ_DMA))) begin
            starve_cnt <= '0;
         end else if (grant) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
         end
`endif
      end
   end

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Self-checking bench for riscv_dmem_arbiter: two instances (MEM_LAT=1,
// STARVE_LIMIT=4 and MEM_LAT=3, STARVE_LIMIT=2) checked every cycle against
// a time-based reference model, plus directed scenarios and random traffic.
module tb_riscv_dmem_arbiter;
   import riscv_dmem_arbiter_pkg::*;

   logic              clk;
   logic              rst;
   logic              cpu_req [2];
   logic              cpu_wen [2];
   logic [XLEN-1:0]   cpu_addr [2];
   logic [XLEN-1:0]   cpu_wd [2];
   logic [BSEL_W-1:0] cpu_bs [2];
   logic              dma_req [2];
   logic              dma_wen [2];
   logic [XLEN-1:0]   dma_addr [2];
   logic [XLEN-1:0]   dma_wd [2];
   logic [BSEL_W-1:0] dma_bs [2];
   logic              cpu_gnt [2];
   logic              cpu_rv [2];
   logic [XLEN-1:0]   cpu_rd [2];
   logic              dma_gnt [2];
   logic              dma_rv [2];
   logic [XLEN-1:0]   dma_rd [2];
   logic              mem_en [2];
   logic              mem_wen [2];
   logic [XLEN-1:0]   mem_addr [2];
   logic [XLEN-1:0]   mem_wd [2];
   logic [BSEL_W-1:0] mem_bs [2];
   logic [XLEN-1:0]   mem_rd [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      riscv_dmem_arbiter #(
         .MEM_LAT      ((g == 0) ? 1 : 3),
         .STARVE_LIMIT ((g == 0) ? 4 : 2)
      ) u_dut (
         .i_clk          (clk),
         .i_rst          (rst),
         .i_cpu_req      (cpu_req[g]),
         .i_cpu_wen      (cpu_wen[g]),
         .i_cpu_addr     (cpu_addr[g]),
         .i_cpu_wr_data  (cpu_wd[g]),
         .i_cpu_byte_sel (cpu_bs[g]),
         .o_cpu_gnt      (cpu_gnt[g]),
         .o_cpu_rvalid   (cpu_rv[g]),
         .o_cpu_rd_data  (cpu_rd[g]),
         .i_dma_req      (dma_req[g]),
         .i_dma_wen      (dma_wen[g]),
         .i_dma_addr     (dma_addr[g]),
         .i_dma_wr_data  (dma_wd[g]),
         .i_dma_byte_sel (dma_bs[g]),
         .o_dma_gnt      (dma_gnt[g]),
         .o_dma_rvalid   (dma_rv[g]),
         .o_dma_rd_data  (dma_rd[g]),
         .o_mem_en       (mem_en[g]),
         .o_mem_wen      (mem_wen[g]),
         .o_mem_addr     (mem_addr[g]),
         .o_mem_wr_data  (mem_wd[g]),
         .o_mem_byte_sel (mem_bs[g]),
         .i_mem_rd_data  (mem_rd[g])
      );
   end

   // Memory model and reference model state
   logic [31:0] mem [2][256];
   logic [31:0] pipe [2][8];
   int          busy_until [2];   // cycle of completion, -1 when nothing outstanding
   logic        own [2];          // 1 = DMA owns the outstanding access
   logic [31:0] own_data [2];     // expected completion data (0 for stores)
`ifdef RISCV_DMEM_ARB_RR_EN
   logic        pref [2];         // 1 = DMA preferred on a tie
`else
   int          streak [2];       // CPU wins while DMA waits
`endif
   logic        eg_c [2];
   logic        eg_d [2];
   logic        m_en [2];
   logic        m_wen [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wd [2];
   logic [3:0]  m_bs [2];
   int          cyc;
   int          n_assert;
   int          n_fail;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

`ifndef RISCV_DMEM_ARB_RR_EN
   function automatic int lim_of(input int k);
      return (k == 0) ? 4 : 2;
   endfunction
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input logic dma, input logic wen,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] bs);
      if (dma) begin
         dma_req[k] = 1'b1; dma_wen[k] = wen; dma_addr[k] = addr; dma_wd[k] = wd; dma_bs[k] = bs;
      end else begin
         cpu_req[k] = 1'b1; cpu_wen[k] = wen; cpu_addr[k] = addr; cpu_wd[k] = wd; cpu_bs[k] = bs;
      end
   endtask

   task automatic rand_req(input int k, input logic dma);
      logic wen;
      wen = 1'($urandom_range(0, 1));
      set_req(k, dma, wen, {22'd0, 8'($urandom), 2'b00}, $urandom,
              wen ? 4'($urandom_range(1, 15)) : 4'hf);
   endtask

   // Mid-cycle: predict outputs from the model and compare.
   task automatic sample();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         logic ec, ed, erc, erd;
         logic [31:0] edata;
         ec = 1'b0; ed = 1'b0; erc = 1'b0; erd = 1'b0; edata = '0;
         if (!rst) begin
            if ((busy_until[k] < 0) || (busy_until[k] == cyc)) begin
               if (cpu_req[k] && dma_req[k]) begin
`ifdef RISCV_DMEM_ARB_RR_EN
                  ed = pref[k];
`else
                  ed = (streak[k] >= lim_of(k));
`endif
                  ec = !ed;
               end else begin
                  ec = cpu_req[k];
                  ed = dma_req[k];
               end
            end
            if (busy_until[k] == cyc) begin
               if (own[k]) erd = 1'b1; else erc = 1'b1;
               edata = own_data[k];
            end
         end
         chk($sformatf("cpu_gnt%0d", k), 32'(cpu_gnt[k]), 32'(ec));
         chk($sformatf("dma_gnt%0d", k), 32'(dma_gnt[k]), 32'(ed));
         chk($sformatf("cpu_rvalid%0d", k), 32'(cpu_rv[k]), 32'(erc));
         chk($sformatf("dma_rvalid%0d", k), 32'(dma_rv[k]), 32'(erd));
         chk($sformatf("cpu_rd%0d", k), cpu_rd[k], erc ? edata : 32'd0);
         chk($sformatf("dma_rd%0d", k), dma_rd[k], erd ? edata : 32'd0);
         chk($sformatf("mem_en%0d", k), 32'(mem_en[k]), 32'(ec | ed));
         if (ec || ed) begin
            chk($sformatf("mem_wen%0d", k), 32'(mem_wen[k]), 32'(ed ? dma_wen[k] : cpu_wen[k]));
            chk($sformatf("mem_addr%0d", k), mem_addr[k], ed ? dma_addr[k] : cpu_addr[k]);
            chk($sformatf("mem_wd%0d", k), mem_wd[k], ed ? dma_wd[k] : cpu_wd[k]);
            chk($sformatf("mem_bs%0d", k), 32'(mem_bs[k]), 32'(ed ? dma_bs[k] : cpu_bs[k]));
         end else begin
            chk($sformatf("mem_wen%0d", k), 32'(mem_wen[k]), 32'd0);
            chk($sformatf("mem_bs%0d", k), 32'(mem_bs[k]), 32'd0);
         end
         eg_c[k] = ec; eg_d[k] = ed;
         m_en[k] = mem_en[k]; m_wen[k] = mem_wen[k]; m_addr[k] = mem_addr[k];
         m_wd[k] = mem_wd[k]; m_bs[k] = mem_bs[k];
      end
   endtask

   // Clock edge: update reference model and memory, then present read data.
   task automatic advance();
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         logic [7:0] idx;
         if (rst) begin
            busy_until[k] = -1;
            own[k] = 1'b0;
`ifdef RISCV_DMEM_ARB_RR_EN
            pref[k] = 1'b0;
`else
            streak[k] = 0;
`endif
         end else begin
            if (eg_c[k] || eg_d[k]) begin
               busy_until[k] = cyc + lat_of(k);
               own[k] = eg_d[k];
               idx = eg_d[k] ? dma_addr[k][9:2] : cpu_addr[k][9:2];
               own_data[k] = (eg_d[k] ? dma_wen[k] : cpu_wen[k]) ? 32'd0 : mem[k][idx];
`ifdef RISCV_DMEM_ARB_RR_EN
               pref[k] = !eg_d[k];
`endif
            end else if (busy_until[k] == cyc) begin
               busy_until[k] = -1;
            end
`ifndef RISCV_DMEM_ARB_RR_EN
            if (!dma_req[k] || eg_d[k]) streak[k] = 0;
            else if (eg_c[k]) streak[k]++;
`endif
         end
         idx = m_addr[k][9:2];
         for (int s = 7; s > 0; s--) pipe[k][s] = pipe[k][s-1];
         pipe[k][0] = (m_en[k] && !m_wen[k]) ? mem[k][idx] : $urandom;
         if (m_en[k] && m_wen[k]) begin
            for (int b = 0; b < 4; b++) begin
               if (m_bs[k][b]) mem[k][idx][8*b +: 8] = m_wd[k][8*b +: 8];
            end
         end
      end
      cyc++;
      #1;
      for (int k = 0; k < 2; k++) mem_rd[k] = pipe[k][lat_of(k)-1];
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   initial begin
      logic [1:0] exp_w;
      n_assert = 0; n_fail = 0; cyc = 0;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cpu_req[k] = 0; cpu_wen[k] = 0; cpu_addr[k] = '0; cpu_wd[k] = '0; cpu_bs[k] = '0;
         dma_req[k] = 0; dma_wen[k] = 0; dma_addr[k] = '0; dma_wd[k] = '0; dma_bs[k] = '0;
         mem_rd[k] = '0; busy_until[k] = -1; own[k] = 0; own_data[k] = '0;
         eg_c[k] = 0; eg_d[k] = 0; m_en[k] = 0; m_wen[k] = 0;
         m_addr[k] = '0; m_wd[k] = '0; m_bs[k] = '0;
`ifdef RISCV_DMEM_ARB_RR_EN
         pref[k] = 0;
`else
         streak[k] = 0;
`endif
         for (int i = 0; i < 256; i++) mem[k][i] = (32'(i) * 32'h01010101) ^ 32'h5a5a0000;
         for (int s = 0; s < 8; s++) pipe[k][s] = '0;
      end
      mem[0][64] = 32'hDEADBEEF;

      // Reset state
      step();
      sample();
      chk("rst_mem_en", 32'(mem_en[0]), 32'd0);
      advance();
      rst = 1'b0;

      // CPU load at latency 1 returns memory data one cycle later
      set_req(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'hf);
      sample();
      chk("t1_gnt", 32'(cpu_gnt[0]), 32'd1);
      chk("t1_addr", mem_addr[0], 32'h100);
      advance();
      cpu_req[0] = 1'b0;
      sample();
      chk("t1_rvalid", 32'(cpu_rv[0]), 32'd1);
      chk("t1_data", cpu_rd[0], 32'hDEADBEEF);
      advance();

      // Store completion: rvalid with zero data, byte enables passed through
      set_req(0, 1'b0, 1'b1, 32'h40, 32'h11223344, 4'b0101);
      sample();
      chk("t6_bsel", 32'(mem_bs[0]), 32'h5);
      chk("t6_wen", 32'(mem_wen[0]), 32'd1);
      advance();
      cpu_req[0] = 1'b0;
      sample();
      chk("t6_rvalid", 32'(cpu_rv[0]), 32'd1);
      chk("t6_rd", cpu_rd[0], 32'd0);
      advance();

      // Both requesters continuously active
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_req(0, 1'b0, 1'b0, 32'h8, 32'h0, 4'hf);
      set_req(0, 1'b1, 1'b0, 32'hc, 32'h0, 4'hf);
      for (int i = 0; i < 10; i++) begin
         sample();
`ifdef RISCV_DMEM_ARB_RR_EN
         exp_w = ((i % 2) == 1) ? 2'b01 : 2'b10;
`else
         exp_w = ((i % 5) == 4) ? 2'b01 : 2'b10;
`endif
         chk($sformatf("t2_gnt%0d", i), 32'({cpu_gnt[0], dma_gnt[0]}), 32'(exp_w));
         advance();
      end
      dma_req[0] = 1'b0;
      sample();
      chk("t3_idle_dma", 32'(dma_gnt[0]), 32'd0);
      chk("t3_cpu", 32'(cpu_gnt[0]), 32'd1);
      advance();
      cpu_req[0] = 1'b0;
      step();

      // Latency 3: CPU store then DMA load; grant window only at completion
      set_req(1, 1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 4'hf);
      sample();
      chk("t4_cgnt", 32'(cpu_gnt[1]), 32'd1);
      advance();
      cpu_req[1] = 1'b0;
      set_req(1, 1'b1, 1'b0, 32'h80, 32'h0, 4'hf);
      for (int j = 1; j <= 2; j++) begin
         sample();
         chk($sformatf("t4_nognt%0d", j), 32'(dma_gnt[1] | mem_en[1]), 32'd0);
         advance();
      end
      sample();
      chk("t4_dgnt", 32'(dma_gnt[1]), 32'd1);
      chk("t4_crv", 32'(cpu_rv[1]), 32'd1);
      chk("t4_crd", cpu_rd[1], 32'd0);
      advance();
      dma_req[1] = 1'b0;
      step();
      step();
      sample();
      chk("t4_drv", 32'(dma_rv[1]), 32'd1);
      chk("t4_drd", dma_rd[1], 32'hCAFEF00D);
      advance();

      // Reset during an outstanding access drops it
      set_req(1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hf);
      sample();
      chk("t5_cgnt", 32'(cpu_gnt[1]), 32'd1);
      advance();
      cpu_req[1] = 1'b0;
      step();
      rst = 1'b1;
      set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hf);
      sample();
      chk("t5_rst_gnt", 32'(dma_gnt[1]), 32'd0);
      advance();
      rst = 1'b0;
      sample();
      chk("t5_dgnt", 32'(dma_gnt[1]), 32'd1);
      chk("t5_norv", 32'(cpu_rv[1]), 32'd0);
      advance();
      dma_req[1] = 1'b0;
      for (int j = 0; j < 4; j++) step();

      // Random traffic on both instances
      for (int n = 0; n < 800; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int k = 0; k < 2; k++) begin
            if (eg_c[k]) cpu_req[k] = 1'b0;
            if (eg_d[k]) dma_req[k] = 1'b0;
            if (!cpu_req[k]) begin
               if ($urandom_range(0, 3) != 0) rand_req(k, 1'b0);
            end else if ($urandom_range(0, 19) == 0) begin
               cpu_req[k] = 1'b0;
            end
            if (!dma_req[k]) begin
               if ($urandom_range(0, 2) != 0) rand_req(k, 1'b1);
            end else if ($urandom_range(0, 19) == 0) begin
               dma_req[k] = 1'b0;
            end
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
